pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised inter-stage pipeline register (ID/EX, EX/MM, MM/WB) with a
//  valid/ready handshake and a 2-entry skid buffer.
//  - Adds stall back-pressure and flush, with zeroed control on bubbles.
//  - Sustains full throughput while keeping in_ready registered.
//  - Splits each payload into data bits (ALU result, PC, operands) and control
//    bits (write enables, dm_rw, opcode), which must read as zero for bubbles.
// PARAMETERS
//  DATA_W      64  payload data width (bits not forced to zero on bubbles)
//  CTRL_W      16  control width (forced to zero whenever out_valid=0)
//  CLEAR_DATA  1   1: flush/bubble also zeroes data regs; 0: data regs hold
//  CNT_W       16  width of the saturating stall counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       synchronous kill of all held entries
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage can accept (registered, = !skid_valid)
//  in_data    in   DATA_W  upstream data
//  in_ctrl    in   CTRL_W  upstream control
//  out_valid  out  1       main entry valid
//  out_ready  in   1       downstream accepts main entry
//  out_data   out  DATA_W  main entry data
//  out_ctrl   out  CTRL_W  main entry control (0 when !out_valid)
//  occupancy  out  2       entries held: 0, 1 or 2
//  stall_cnt  out  CNT_W   cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - All registers and outputs are 0, except in_ready=1.
//    - State is EMPTY.
//  - Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//    - in_valid may be asserted without waiting for in_ready.
//    - in_data and in_ctrl are sampled only on in_fire.
//  - Latency: an accepted entry appears on out_* on the next cycle when the
//    stage was EMPTY, or the stage was ONE with out_fire.
//  - States: EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
//    - EMPTY: in_fire -> main<=in, ONE.
//    - ONE: in_fire & out_fire -> main<=in, stay ONE.
//    - ONE: in_fire & !out_fire -> skid<=in, FULL.
//    - ONE: !in_fire & out_fire -> EMPTY.
//    - FULL: in_ready=0. out_fire -> main<=skid, ONE. Otherwise hold.
//  - Ordering: entries leave in acceptance order; none is duplicated or lost
//    unless flushed.
//  - Flush has priority over all other events in the same cycle:
//    - Next state is EMPTY; main/skid valid and ctrl regs are cleared.
//    - Data regs are cleared iff CLEAR_DATA=1.
//    - Any in_fire in the flush cycle is discarded.
//    - out_fire in the flush cycle still counts as delivered downstream.
//  - out_ctrl is 0 whenever out_valid=0, so a bubble is a NOP.
//  - stall_cnt:
//    - Increments when out_valid & !out_ready; saturates at 2^CNT_W-1.
//    - Unaffected by flush; cleared only by reset.
//  - in_ready depends only on state; there is no combinational in->out path.
//  - Reset mid-transfer drops all entries immediately (async).
// TESTING
//  - Reset: assert rst_n=0 mid-FULL.
//    -> out_valid=0, occupancy=0, in_ready=1, out_ctrl=0 with no clock edge.
//  - Streaming: in_valid=1 for 8 cycles with data 1..8, out_ready=1.
//    -> out_data 1..8 on consecutive cycles starting 1 cycle after first
//       accept; occupancy stays 1.
//  - Back-pressure: push A,B,C with out_ready=0.
//    -> A,B accepted, occupancy=2, in_ready=0, C held upstream.
//    -> Raise out_ready: out shows A, B, C in order; stall_cnt = stall cycles.
//  - Flush in FULL with in_valid=1 (data D) in the same cycle.
//    -> Next cycle: occupancy=0, out_valid=0, out_ctrl=0; D never appears.
//    -> out_data=0 when CLEAR_DATA=1, and the old value when CLEAR_DATA=0.
//  - Saturation (CNT_W=4): out_valid held, out_ready=0 for 20 cycles.
//    -> stall_cnt stops at 15.
//  - Random valid/ready/flush, 10k cycles, scoreboard.
//    -> Output sequence equals accepted-minus-flushed sequence.
//    -> out_ctrl==0 whenever !out_valid.

Source files
------------

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle between a pipeline stage and its neighbours.
// The upstream side is in_*, the downstream side is out_*.
interface pipe_stage_elastic_if #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;

   // Environment view: drives the upstream entry and the downstream ready
   modport master (
      output in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl
   );

   // Stage view: accepts upstream entries and presents the main entry
   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl
   );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with a main entry and a skid entry.
// in_ready is decoded from the state register only, so there is no
// combinational path from out_ready back to in_ready. Control bits read as
// zero whenever the stage presents a bubble.
module pipe_stage_elastic #(
   parameter int DATA_W     = 64,
   parameter int CTRL_W     = 16,
   parameter int CLEAR_DATA = 1,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   pipe_stage_elastic_if.slave  bus,
   output logic [1:0]           occupancy,
   output logic [CNT_W-1:0]     stall_cnt
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              in_fire;
   logic              out_fire;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid_in;
   logic              clear_main;
   logic              clear_skid;

   // Outputs decoded from the state register and the main entry
   always_comb begin
      bus.in_ready  = (state != FULL);
      bus.out_valid = (state != EMPTY);
      bus.out_data  = main_data;
      bus.out_ctrl  = (state != EMPTY) ? main_ctrl : '0;
      in_fire       = bus.in_valid && (state != FULL);
      out_fire      = (state != EMPTY) && bus.out_ready;
      case (state)
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // State register; reset drops every held entry immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_next;
   end

   // Next state and register-load decisions; flush overrides everything and
   // silently discards an entry accepted in the same cycle
   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      clear_main     = 1'b0;
      clear_skid     = 1'b0;
      if (flush) begin
         state_next = EMPTY;
         clear_main = 1'b1;
         clear_skid = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  load_main_in = 1'b1;
                  state_next   = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (in_fire) begin
                  load_skid_in = 1'b1;
                  state_next   = FULL;
               end else if (out_fire) begin
                  clear_main = 1'b1;
                  state_next = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  load_main_skid = 1'b1;
                  clear_skid     = 1'b1;
                  state_next     = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // Main entry registers; emptied slots get zero control (and data if enabled)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_data <= '0;
         main_ctrl <= '0;
      end else if (clear_main) begin
         main_ctrl <= '0;
         if (CLEAR_DATA != 0) main_data <= '0;
      end else if (load_main_in) begin
         main_data <= bus.in_data;
         main_ctrl <= bus.in_ctrl;
      end else if (load_main_skid) begin
         main_data <= skid_data;
         main_ctrl <= skid_ctrl;
      end
   end

   // Skid entry registers; catch the entry that arrives while main is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_data <= '0;
         skid_ctrl <= '0;
      end else if (clear_skid) begin
         skid_ctrl <= '0;
         if (CLEAR_DATA != 0) skid_data <= '0;
      end else if (load_skid_in) begin
         skid_data <= bus.in_data;
         skid_ctrl <= bus.in_ctrl;
      end
   end

   // Saturating count of cycles where a valid entry waits on downstream;
   // flush deliberately does not touch it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (bus.out_valid && !bus.out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and scoreboard checks for pipe_stage_elastic. Two instances share
// one stimulus: dut_a clears data on bubbles with a 4-bit stall counter,
// dut_b holds data with a 16-bit stall counter.
module tb_pipe_stage_elastic;

   typedef struct packed {
      logic [63:0] d;
      logic [15:0] c;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  occ_a;
   logic [1:0]  occ_b;
   logic [3:0]  stall_a;
   logic [15:0] stall_b;
   int          n_compared = 0;
   int          n_mismatched = 0;

   pipe_stage_elastic_if #(.DATA_W(64), .CTRL_W(16)) bus_a ();
   pipe_stage_elastic_if #(.DATA_W(64), .CTRL_W(16)) bus_b ();

   assign bus_b.in_valid  = bus_a.in_valid;
   assign bus_b.in_data   = bus_a.in_data;
   assign bus_b.in_ctrl   = bus_a.in_ctrl;
   assign bus_b.out_ready = bus_a.out_ready;

   pipe_stage_elastic #(.DATA_W(64), .CTRL_W(16), .CLEAR_DATA(1), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a),
      .occupancy(occ_a), .stall_cnt(stall_a)
   );

   pipe_stage_elastic #(.DATA_W(64), .CTRL_W(16), .CLEAR_DATA(0), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b),
      .occupancy(occ_b), .stall_cnt(stall_b)
   );

   always #5 clk = ~clk;

   // Advance one cycle and settle just after the rising edge
   task step;
      @(posedge clk);
      #1;
   endtask

   task drive_idle;
      bus_a.in_valid  = 1'b0;
      bus_a.in_data   = '0;
      bus_a.in_ctrl   = '0;
      bus_a.out_ready = 1'b0;
      flush           = 1'b0;
   endtask

   task do_reset;
      drive_idle();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task push(input logic [63:0] d, input logic [15:0] c);
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = d;
      bus_a.in_ctrl  = c;
      step();
   endtask

   // Reset values, then asynchronous reset while FULL
   task test_reset;
      drive_idle();
      rst_n = 1'b0;
      step();
      n_compared++;
      if ({bus_a.out_valid, bus_a.in_ready, occ_a, stall_a, bus_a.out_ctrl, bus_a.out_data} !==
          {1'b0, 1'b1, 2'd0, 4'd0, 16'h0, 64'h0}) begin
         n_mismatched++;
         $display("[TB] FAIL reset_values: got v=%b r=%b occ=%0d st=%0d ctrl=%h data=%h, expected v=0 r=1 occ=0 st=0 ctrl=0 data=0",
                  bus_a.out_valid, bus_a.in_ready, occ_a, stall_a, bus_a.out_ctrl, bus_a.out_data);
      end
      rst_n = 1'b1;
      push(64'h5, 16'h5);
      push(64'h6, 16'h6);
      bus_a.in_valid = 1'b0;
      n_compared++;
      if (occ_a !== 2'd2) begin
         n_mismatched++;
         $display("[TB] FAIL reset_fill: occupancy got %0d expected 2", occ_a);
      end
      #3;
      rst_n = 1'b0;
      #1;
      n_compared++;
      if ({bus_a.out_valid, occ_a, bus_a.in_ready, bus_a.out_ctrl, occ_b} !== {1'b0, 2'd0, 1'b1, 16'h0, 2'd0}) begin
         n_mismatched++;
         $display("[TB] FAIL reset_async: got v=%b occ=%0d r=%b ctrl=%h occ_b=%0d, expected v=0 occ=0 r=1 ctrl=0 occ_b=0",
                  bus_a.out_valid, occ_a, bus_a.in_ready, bus_a.out_ctrl, occ_b);
      end
      step();
      rst_n = 1'b1;
   endtask

   // Eight back-to-back entries with downstream always ready
   task test_stream;
      do_reset();
      bus_a.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push(64'(i), 16'(16'h100 + i));
         n_compared++;
         if ({bus_a.out_valid, bus_a.out_data, bus_a.out_ctrl, occ_a, bus_a.in_ready} !==
             {1'b1, 64'(i), 16'(16'h100 + i), 2'd1, 1'b1}) begin
            n_mismatched++;
            $display("[TB] FAIL stream_%0d: got v=%b data=%h ctrl=%h occ=%0d r=%b, expected v=1 data=%h ctrl=%h occ=1 r=1",
                     i, bus_a.out_valid, bus_a.out_data, bus_a.out_ctrl, occ_a, bus_a.in_ready, i, 16'h100 + i);
         end
      end
      bus_a.in_valid = 1'b0;
      step();
      n_compared++;
      if ({bus_a.out_valid, bus_a.out_ctrl, occ_a, bus_a.out_data, bus_b.out_ctrl, bus_b.out_data} !==
          {1'b0, 16'h0, 2'd0, 64'h0, 16'h0, 64'h8}) begin
         n_mismatched++;
         $display("[TB] FAIL stream_bubble: got v=%b ctrl=%h occ=%0d data_a=%h ctrl_b=%h data_b=%h, expected v=0 ctrl=0 occ=0 data_a=0 ctrl_b=0 data_b=8",
                  bus_a.out_valid, bus_a.out_ctrl, occ_a, bus_a.out_data, bus_b.out_ctrl, bus_b.out_data);
      end
      drive_idle();
   endtask

   // Fill both entries with downstream stalled, then drain in order
   task test_back_pressure;
      do_reset();
      push(64'hA, 16'h0A);
      push(64'hB, 16'h0B);
      n_compared++;
      if ({occ_a, bus_a.in_ready, bus_a.out_data} !== {2'd2, 1'b0, 64'hA}) begin
         n_mismatched++;
         $display("[TB] FAIL bp_full: got occ=%0d r=%b data=%h, expected occ=2 r=0 data=a", occ_a, bus_a.in_ready, bus_a.out_data);
      end
      push(64'hC, 16'h0C);
      step();
      n_compared++;
      if ({occ_a, bus_a.in_ready, bus_a.out_data, stall_a} !== {2'd2, 1'b0, 64'hA, 4'd3}) begin
         n_mismatched++;
         $display("[TB] FAIL bp_hold: got occ=%0d r=%b data=%h stall=%0d, expected occ=2 r=0 data=a stall=3",
                  occ_a, bus_a.in_ready, bus_a.out_data, stall_a);
      end
      bus_a.out_ready = 1'b1;
      step();
      n_compared++;
      if ({occ_a, bus_a.in_ready, bus_a.out_data, bus_a.out_ctrl} !== {2'd1, 1'b1, 64'hB, 16'h0B}) begin
         n_mismatched++;
         $display("[TB] FAIL bp_drain_b: got occ=%0d r=%b data=%h ctrl=%h, expected occ=1 r=1 data=b ctrl=b",
                  occ_a, bus_a.in_ready, bus_a.out_data, bus_a.out_ctrl);
      end
      step();
      bus_a.in_valid = 1'b0;
      n_compared++;
      if ({occ_a, bus_a.out_data, bus_a.out_ctrl} !== {2'd1, 64'hC, 16'h0C}) begin
         n_mismatched++;
         $display("[TB] FAIL bp_drain_c: got occ=%0d data=%h ctrl=%h, expected occ=1 data=c ctrl=c",
                  occ_a, bus_a.out_data, bus_a.out_ctrl);
      end
      step();
      n_compared++;
      if ({bus_a.out_valid, occ_a, stall_a, stall_b} !== {1'b0, 2'd0, 4'd3, 16'd3}) begin
         n_mismatched++;
         $display("[TB] FAIL bp_done: got v=%b occ=%0d stall_a=%0d stall_b=%0d, expected v=0 occ=0 stall_a=3 stall_b=3",
                  bus_a.out_valid, occ_a, stall_a, stall_b);
      end
      drive_idle();
   endtask

   // Flush while FULL and while ONE with a simultaneous accept
   task test_flush;
      do_reset();
      push(64'h11, 16'h1);
      push(64'h22, 16'h2);
      bus_a.in_data = 64'hDD;
      bus_a.in_ctrl = 16'hD;
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus_a.in_valid = 1'b0;
      n_compared++;
      if ({occ_a, bus_a.out_valid, bus_a.out_ctrl, bus_a.out_data, occ_b, bus_b.out_ctrl, bus_b.out_data} !==
          {2'd0, 1'b0, 16'h0, 64'h0, 2'd0, 16'h0, 64'h11}) begin
         n_mismatched++;
         $display("[TB] FAIL flush_full: got occ=%0d v=%b ctrl=%h data_a=%h occ_b=%0d ctrl_b=%h data_b=%h, expected 0 0 0 0 0 0 11",
                  occ_a, bus_a.out_valid, bus_a.out_ctrl, bus_a.out_data, occ_b, bus_b.out_ctrl, bus_b.out_data);
      end
      push(64'h31, 16'h3);
      bus_a.in_data = 64'hEE;
      bus_a.in_ctrl = 16'hE;
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus_a.in_valid = 1'b0;
      n_compared++;
      if ({occ_a, bus_a.out_valid} !== {2'd0, 1'b0}) begin
         n_mismatched++;
         $display("[TB] FAIL flush_one: got occ=%0d v=%b, expected occ=0 v=0", occ_a, bus_a.out_valid);
      end
      step();
      n_compared++;
      if ({bus_a.out_valid, bus_a.out_data} !== {1'b0, 64'h0}) begin
         n_mismatched++;
         $display("[TB] FAIL flush_no_ghost: got v=%b data=%h, expected v=0 data=0", bus_a.out_valid, bus_a.out_data);
      end
      drive_idle();
   endtask

   // Long stall: 4-bit counter saturates, flush leaves counters alone
   task test_saturation;
      do_reset();
      push(64'h77, 16'h7);
      bus_a.in_valid = 1'b0;
      for (int i = 0; i < 14; i++) step();
      n_compared++;
      if (stall_a !== 4'd14) begin
         n_mismatched++;
         $display("[TB] FAIL sat_pre: stall_a got %0d expected 14", stall_a);
      end
      for (int i = 0; i < 6; i++) step();
      n_compared++;
      if ({stall_a, stall_b} !== {4'd15, 16'd20}) begin
         n_mismatched++;
         $display("[TB] FAIL sat_stop: got stall_a=%0d stall_b=%0d expected 15 and 20", stall_a, stall_b);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      n_compared++;
      if ({stall_a, stall_b, bus_a.out_valid} !== {4'd15, 16'd21, 1'b0}) begin
         n_mismatched++;
         $display("[TB] FAIL sat_flush: got stall_a=%0d stall_b=%0d v=%b expected 15 21 0", stall_a, stall_b, bus_a.out_valid);
      end
      drive_idle();
   endtask

   // Random valid/ready/flush traffic against a queue model
   task test_random;
      entry_t      q[$];
      entry_t      e;
      entry_t      head;
      logic        iv;
      logic        ordy;
      logic        fl;
      logic        in_fire_m;
      logic        out_fire_m;
      logic [15:0] stall_m;
      logic [83:0] got_a;
      logic [83:0] exp_a;
      logic [99:0] got_b;
      logic [99:0] exp_b;
      do_reset();
      stall_m = 16'd0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         head  = (q.size() > 0) ? q[0] : '0;
         exp_a = {q.size() > 0, 2'(q.size()), q.size() < 2, head.c, head.d};
         got_a = {bus_a.out_valid, occ_a, bus_a.in_ready, bus_a.out_ctrl, bus_a.out_data};
         n_compared++;
         if (got_a !== exp_a) begin
            n_mismatched++;
            $display("[TB] FAIL random_a cycle %0d: got %h expected %h", cyc, got_a, exp_a);
         end
         exp_b = {q.size() > 0, 2'(q.size()), q.size() < 2, head.c, head.d, stall_m};
         got_b = {bus_b.out_valid, occ_b, bus_b.in_ready, bus_b.out_ctrl,
                  (bus_b.out_valid ? bus_b.out_data : 64'h0), stall_b};
         n_compared++;
         if (got_b !== exp_b) begin
            n_mismatched++;
            $display("[TB] FAIL random_b cycle %0d: got %h expected %h", cyc, got_b, exp_b);
         end
         iv   = ($urandom_range(0, 9) < 6);
         ordy = ($urandom_range(0, 9) < 6);
         fl   = ($urandom_range(0, 31) == 0);
         e.d  = {$urandom, $urandom};
         e.c  = 16'($urandom);
         bus_a.in_valid  = iv;
         bus_a.in_data   = e.d;
         bus_a.in_ctrl   = e.c;
         bus_a.out_ready = ordy;
         flush           = fl;
         in_fire_m  = iv && (q.size() < 2);
         out_fire_m = (q.size() > 0) && ordy;
         if ((q.size() > 0) && !ordy && (stall_m != 16'hFFFF)) stall_m = stall_m + 16'd1;
         if (fl) begin
            q.delete();
         end else begin
            if (out_fire_m) void'(q.pop_front());
            if (in_fire_m) q.push_back(e);
         end
         step();
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_stream();
      test_back_pressure();
      test_flush();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
